// File: rtl/gp_wb_pkg.sv
// gp_wb_pkg: shared types, defaults and helpers for the Wishbone stimulus responder.
//   wb_state_e     - responder FSM states
//   FILL_WORD_DEF  - default NOP word for unused lanes and queue starvation
//   lane_count()   - number of 32-bit lanes on a bus of the given width
package gp_wb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STALL = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } wb_state_e;

    localparam logic [31:0] FILL_WORD_DEF = 32'hF0801003;

    function automatic int lane_count(input int data_w);
        return data_w / 32;
    endfunction

endpackage

// File: rtl/gp_sync_fifo.sv
// gp_sync_fifo: single-clock FIFO with first-word-fall-through head.
//   i_clk, i_rst_n      - clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_din       - write; ignored while full, even if a pop happens that cycle
//   i_pop, o_dout       - read; o_dout shows the head, pop ignored while empty
//   o_full, o_empty     - status
//   o_count             - current occupancy
module gp_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_dout  = r_mem[r_rp];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/gp_wb_stim_responder.sv
// gp_wb_stim_responder: Wishbone classic slave serving queued instructions and capturing stores.
//   i_clk, i_rst_n                 - clock, asynchronous active-low reset
//   i_wb_* / o_wb_*                - Wishbone classic slave port
//   i_ack_lat                      - extra wait cycles before each response
//   i_err_req                      - arm a one-shot error response
//   i_in_valid/o_in_ready/i_in_inst - instruction queue push
//   o_st_valid/i_st_ready/o_st_*   - captured store FIFO head and pop
//   o_rd_cnt/o_wr_cnt/o_starve_cnt - completed reads, writes, starved reads
module gp_wb_stim_responder
    import gp_wb_pkg::*;
#(
    parameter int          DATA_W      = 128,
    parameter int          ADDR_W      = 32,
    parameter int          INST_DEPTH  = 8,
    parameter int          STORE_DEPTH = 8,
    parameter int          LAT_W       = 4,
    parameter logic [31:0] FILL_WORD   = FILL_WORD_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    input  logic                i_wb_we,
    input  logic [ADDR_W-1:0]   i_wb_adr,
    input  logic [DATA_W/8-1:0] i_wb_sel,
    input  logic [DATA_W-1:0]   i_wb_dat,
    output logic [DATA_W-1:0]   o_wb_dat,
    output logic                o_wb_ack,
    output logic                o_wb_err,
    input  logic [LAT_W-1:0]    i_ack_lat,
    input  logic                i_err_req,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [31:0]         i_in_inst,
    output logic                o_st_valid,
    input  logic                i_st_ready,
    output logic [ADDR_W-1:0]   o_st_adr,
    output logic [DATA_W/8-1:0] o_st_sel,
    output logic [DATA_W-1:0]   o_st_dat,
    output logic [15:0]         o_rd_cnt,
    output logic [15:0]         o_wr_cnt,
    output logic [15:0]         o_starve_cnt
);

    localparam int LANES  = lane_count(DATA_W);
    localparam int SEL_W  = DATA_W / 8;
    localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int ICNT_W = $clog2(INST_DEPTH) + 1;
    localparam int SCNT_W = $clog2(STORE_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] adr;
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] dat;
    } st_rec_t;

    wb_state_e         r_state;
    logic [ADDR_W-1:0] r_adr;
    logic              r_we;
    logic [SEL_W-1:0]  r_sel;
    logic [DATA_W-1:0] r_dat;
    logic [LAT_W-1:0]  r_cnt;
    logic              r_err_armed;
    logic              r_resp_err;
    logic              r_starve;
    logic [DATA_W-1:0] r_rdat;
    logic [15:0]       r_rd_cnt;
    logic [15:0]       r_wr_cnt;
    logic [15:0]       r_starve_cnt;

    logic [31:0]       w_inst_head;
    logic              w_inst_empty;
    logic              w_inst_full;
    logic [ICNT_W-1:0] w_inst_count;
    logic              w_inst_pop;
    st_rec_t           w_st_din;
    st_rec_t           w_st_head;
    logic              w_st_full;
    logic              w_st_empty;
    logic [SCNT_W-1:0] w_st_count;
    logic              w_st_push;
    logic [LIDX_W-1:0] w_lane;
    logic [DATA_W-1:0] w_rdat;
    logic              w_to_resp;
    logic              w_err_now;
    logic              w_rd_go;
    logic              w_resp_ok;
    logic              w_unused;

    // Response decisions (error vs. normal, pop, read data) are all taken on
    // the cycle that enters RESP so the data is registered into RESP itself.
    assign w_to_resp = i_wb_cyc && ((r_state == ST_WAIT && r_cnt == '0 && !(r_we && w_st_full))
                                 || (r_state == ST_STALL && !w_st_full));
    assign w_err_now  = r_err_armed || i_err_req;
    assign w_rd_go    = w_to_resp && !r_we && !w_err_now;
    assign w_inst_pop = w_rd_go && !w_inst_empty;
    assign w_resp_ok  = r_state == ST_RESP && !r_resp_err;
    assign w_st_push  = w_resp_ok && r_we;
    assign w_st_din   = '{adr: r_adr, sel: r_sel, dat: r_dat};

    assign o_wb_ack     = r_state == ST_RESP && !r_resp_err;
    assign o_wb_err     = r_state == ST_RESP && r_resp_err;
    assign o_wb_dat     = r_rdat;
    assign o_in_ready   = w_inst_count != ICNT_W'(INST_DEPTH);
    assign o_st_valid   = !w_st_empty;
    assign o_st_adr     = w_st_head.adr;
    assign o_st_sel     = w_st_head.sel;
    assign o_st_dat     = w_st_head.dat;
    assign o_rd_cnt     = r_rd_cnt;
    assign o_wr_cnt     = r_wr_cnt;
    assign o_starve_cnt = r_starve_cnt;
    assign w_unused     = ^{w_inst_full, w_st_count};

    generate
        if (LANES > 1) begin : g_lane_sel
            assign w_lane = r_adr[$clog2(SEL_W)-1:2];
        end else begin : g_lane_one
            assign w_lane = '0;
        end
        for (genvar g = 0; g < LANES; g++) begin : g_lane
            assign w_rdat[g*32 +: 32] = (!w_inst_empty && w_lane == LIDX_W'(g)) ? w_inst_head : FILL_WORD;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_adr        <= '0;
            r_we         <= 1'b0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_cnt        <= '0;
            r_err_armed  <= 1'b0;
            r_resp_err   <= 1'b0;
            r_starve     <= 1'b0;
            r_rdat       <= {LANES{FILL_WORD}};
            r_rd_cnt     <= '0;
            r_wr_cnt     <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_wb_cyc && i_wb_stb) begin
                    r_adr   <= i_wb_adr;
                    r_we    <= i_wb_we;
                    r_sel   <= i_wb_sel;
                    r_dat   <= i_wb_dat;
                    r_cnt   <= i_ack_lat;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: if (!i_wb_cyc) r_state <= ST_IDLE;
                    else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                    else r_state <= (r_we && w_st_full) ? ST_STALL : ST_RESP;
                ST_STALL: if (!i_wb_cyc) r_state <= ST_IDLE;
                    else if (!w_st_full) r_state <= ST_RESP;
                ST_RESP: r_state <= ST_GAP;
                default: r_state <= ST_IDLE;
            endcase
            // A request arriving during RESP is not consumed here, so it arms the next transaction.
            r_err_armed <= w_to_resp ? 1'b0 : w_err_now;
            if (w_to_resp) begin
                r_resp_err <= w_err_now;
                r_starve   <= w_inst_empty;
            end
            if (w_rd_go) r_rdat <= w_rdat;
            if (w_resp_ok && !r_we) r_rd_cnt <= r_rd_cnt + 16'd1;
            if (w_resp_ok && !r_we && r_starve && r_starve_cnt != 16'hFFFF) r_starve_cnt <= r_starve_cnt + 16'd1;
            if (w_resp_ok && r_we) r_wr_cnt <= r_wr_cnt + 16'd1;
        end
    end

    gp_sync_fifo #(.WIDTH(32), .DEPTH(INST_DEPTH)) u_inst_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_in_valid && o_in_ready),
        .i_din   (i_in_inst),
        .i_pop   (w_inst_pop),
        .o_dout  (w_inst_head),
        .o_full  (w_inst_full),
        .o_empty (w_inst_empty),
        .o_count (w_inst_count)
    );

    gp_sync_fifo #(.WIDTH($bits(st_rec_t)), .DEPTH(STORE_DEPTH)) u_st_q (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_st_push),
        .i_din   (w_st_din),
        .i_pop   (o_st_valid && i_st_ready),
        .o_dout  (w_st_head),
        .o_full  (w_st_full),
        .o_empty (w_st_empty),
        .o_count (w_st_count)
    );

endmodule

// File: tb/tb_gp_wb_stim_responder.sv
// tb_gp_wb_stim_responder: directed bench for gp_wb_stim_responder with hand-computed expectations.
module tb_gp_wb_stim_responder;

    localparam logic [31:0]  F     = 32'hF0801003;
    localparam logic [127:0] FILL4 = {4{F}};
    localparam logic [127:0] BEEF4 = {4{32'hDEADBEEF}};

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_wb_cyc, i_wb_stb, i_wb_we;
    logic [31:0]  i_wb_adr;
    logic [15:0]  i_wb_sel;
    logic [127:0] i_wb_dat;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack, o_wb_err;
    logic [3:0]   i_ack_lat;
    logic         i_err_req, i_in_valid, o_in_ready;
    logic [31:0]  i_in_inst;
    logic         o_st_valid, i_st_ready;
    logic [31:0]  o_st_adr;
    logic [15:0]  o_st_sel;
    logic [127:0] o_st_dat;
    logic [15:0]  o_rd_cnt, o_wr_cnt, o_starve_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 i_clk = ~i_clk;

    gp_wb_stim_responder #(
        .DATA_W(128), .ADDR_W(32), .INST_DEPTH(8), .STORE_DEPTH(2), .LAT_W(4)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_adr(i_wb_adr), .i_wb_sel(i_wb_sel), .i_wb_dat(i_wb_dat),
        .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack), .o_wb_err(o_wb_err),
        .i_ack_lat(i_ack_lat), .i_err_req(i_err_req),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_inst(i_in_inst),
        .o_st_valid(o_st_valid), .i_st_ready(i_st_ready),
        .o_st_adr(o_st_adr), .o_st_sel(o_st_sel), .o_st_dat(o_st_dat),
        .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt), .o_starve_cnt(o_starve_cnt)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(posedge i_clk);
        #1 i_in_valid = 1'b1;
        i_in_inst = w;
        @(posedge i_clk);
        #1 i_in_valid = 1'b0;
    endtask

    task automatic start(input logic we, input logic [31:0] adr, input logic [127:0] dat);
        @(posedge i_clk);
        #1 i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        i_wb_we  = we;
        i_wb_adr = adr;
        i_wb_dat = dat;
        i_wb_sel = 16'hFFFF;
    endtask

    task automatic release_bus();
        @(posedge i_clk);
        #1 i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
    endtask

    // lat counts cycles from the one where stb is first presented to the response cycle.
    task automatic bus(input logic we, input logic [31:0] adr, input logic [127:0] dat,
                       output int lat, output logic ack, output logic err,
                       output logic [127:0] rd, output logic resp_after);
        start(we, adr, dat);
        lat = 0;
        ack = 1'b0;
        err = 1'b0;
        rd  = '0;
        while (lat < 40 && !(ack || err)) begin
            @(negedge i_clk);
            if (o_wb_ack || o_wb_err) begin
                ack = o_wb_ack;
                err = o_wb_err;
                rd  = o_wb_dat;
            end else lat++;
        end
        release_bus();
        @(negedge i_clk);
        resp_after = o_wb_ack || o_wb_err;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           lat, n;
        logic         ack, err, aa;
        logic [127:0] rd;
        logic [31:0]  w;
        i_rst_n = 1'b0;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_adr = '0; i_wb_sel = '0; i_wb_dat = '0;
        i_ack_lat = '0; i_err_req = 1'b0; i_in_valid = 1'b0; i_in_inst = '0; i_st_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_ack", o_wb_ack, 1'b0);
        check("rst_err", o_wb_err, 1'b0);
        check("rst_dat", o_wb_dat, FILL4);
        check("rst_st_valid", o_st_valid, 1'b0);
        check("rst_in_ready", o_in_ready, 1'b1);
        check("rst_cnts", {o_rd_cnt, o_wr_cnt, o_starve_cnt}, 48'h0);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;

        // Single instruction in lane 2 (adr 0x8), zero extra latency.
        push(32'hE3A01005);
        i_ack_lat = 4'd0;
        bus(1'b0, 32'h8, '0, lat, ack, err, rd, aa);
        check("t1_lat", lat, 2);
        check("t1_ack", {ack, err}, 2'b10);
        check("t1_dat", rd, 128'hF0801003_E3A01005_F0801003_F0801003);
        check("t1_one_cycle", aa, 1'b0);
        check("t1_rd_cnt", o_rd_cnt, 16'd1);
        check("t1_starve", o_starve_cnt, 16'd0);

        // Starved read with three wait cycles.
        i_ack_lat = 4'd3;
        bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
        check("t2_lat", lat, 5);
        check("t2_ack", ack, 1'b1);
        check("t2_dat", rd, FILL4);
        check("t2_starve", o_starve_cnt, 16'd1);
        check("t2_rd_cnt", o_rd_cnt, 16'd2);

        // Store FIFO of depth 2 back-pressures the third write.
        i_ack_lat = 4'd0;
        bus(1'b1, 32'h10, BEEF4, lat, ack, err, rd, aa);
        check("t3_w1_ack", ack, 1'b1);
        bus(1'b1, 32'h10, BEEF4, lat, ack, err, rd, aa);
        check("t3_w2_ack", ack, 1'b1);
        check("t3_wr_cnt2", o_wr_cnt, 16'd2);
        start(1'b1, 32'h10, BEEF4);
        n = 0;
        repeat (8) begin
            @(negedge i_clk);
            if (o_wb_ack || o_wb_err) n++;
        end
        check("t3_stall_noack", n, 0);
        check("t3_st_valid", o_st_valid, 1'b1);
        @(posedge i_clk);
        #1 i_st_ready = 1'b1;
        @(posedge i_clk);
        #1 i_st_ready = 1'b0;
        lat = 0;
        ack = 1'b0;
        while (lat < 20 && !ack) begin
            @(negedge i_clk);
            if (o_wb_ack) ack = 1'b1;
            else lat++;
        end
        check("t3_w3_ack", ack, 1'b1);
        check("t3_st_adr", o_st_adr, 32'h10);
        check("t3_st_sel", o_st_sel, 16'hFFFF);
        check("t3_st_dat", o_st_dat, BEEF4);
        release_bus();
        @(negedge i_clk);
        check("t3_wr_cnt3", o_wr_cnt, 16'd3);
        @(posedge i_clk);
        #1 i_st_ready = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_st_ready = 1'b0;
        @(negedge i_clk);
        check("t3_drained", o_st_valid, 1'b0);

        // One-shot error leaves the queued instruction in place.
        push(32'h11111111);
        @(posedge i_clk);
        #1 i_err_req = 1'b1;
        @(posedge i_clk);
        #1 i_err_req = 1'b0;
        bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
        check("t4_err", {ack, err}, 2'b01);
        check("t4_err_one_cycle", aa, 1'b0);
        check("t4_rd_cnt_hold", o_rd_cnt, 16'd2);
        bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
        check("t4_ack_after_err", {ack, err}, 2'b10);
        check("t4_dat", rd, {F, F, F, 32'h11111111});
        check("t4_rd_cnt", o_rd_cnt, 16'd3);
        check("t4_starve_hold", o_starve_cnt, 16'd1);

        // Fill the queue, reject a ninth push, abort a read in WAIT.
        for (int i = 0; i < 8; i++) push(32'hA0000000 + 32'(i));
        check("t5_full", o_in_ready, 1'b0);
        push(32'hBAD00009);
        check("t5_full_after_9th", o_in_ready, 1'b0);
        i_ack_lat = 4'd5;
        start(1'b0, 32'h0, '0);
        repeat (3) @(negedge i_clk);
        release_bus();
        n = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_wb_ack || o_wb_err) n++;
        end
        check("t5_abort_noresp", n, 0);
        check("t5_abort_full", o_in_ready, 1'b0);
        check("t5_abort_rd_cnt", o_rd_cnt, 16'd3);
        i_ack_lat = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w = 32'hA0000000 + 32'(i);
            bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
            check("t5_drain", rd, {F, F, F, w});
            if (i == 0) check("t5_ready_after_pop", o_in_ready, 1'b1);
        end
        bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
        check("t5_9th_ignored", rd, FILL4);
        check("t5_starve", o_starve_cnt, 16'd2);
        check("t5_rd_cnt", o_rd_cnt, 16'd12);

        // Reset asserted while a write is stalled.
        push(32'h22222222);
        bus(1'b0, 32'h4, '0, lat, ack, err, rd, aa);
        check("t6_lane1", rd, {F, F, 32'h22222222, F});
        push(32'h33333333);
        bus(1'b1, 32'h20, BEEF4, lat, ack, err, rd, aa);
        bus(1'b1, 32'h20, BEEF4, lat, ack, err, rd, aa);
        start(1'b1, 32'h20, BEEF4);
        n = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_wb_ack || o_wb_err) n++;
        end
        check("t6_stalled", n, 0);
        check("t6_pre_wr_cnt", o_wr_cnt, 16'd5);
        i_rst_n  = 1'b0;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        #1;
        check("t6_rst_ackerr", {o_wb_ack, o_wb_err}, 2'b00);
        check("t6_rst_dat", o_wb_dat, FILL4);
        check("t6_rst_st_valid", o_st_valid, 1'b0);
        check("t6_rst_in_ready", o_in_ready, 1'b1);
        check("t6_rst_cnts", {o_rd_cnt, o_wr_cnt, o_starve_cnt}, 48'h0);
        repeat (2) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        bus(1'b0, 32'h0, '0, lat, ack, err, rd, aa);
        check("t6_queue_cleared", rd, FILL4);
        check("t6_starve", o_starve_cnt, 16'd1);
        check("t6_rd_cnt", o_rd_cnt, 16'd1);
        check("t6_st_empty", o_st_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
